sram1rw_param: RTL



---
 rtl/sram1rw_param_pkg.sv | 27 ++
 rtl/sram1rw_param_if.sv | 32 +++
 rtl/sram1rw_param_lane.sv | 24 ++
 rtl/sram1rw_param.sv | 111 +++++++++++
 4 files changed

// File: rtl/sram1rw_param_pkg.sv
// Shared definitions for the parameterised single-port SRAM: address-width helper,
// controller state encoding and the legal read-latency range.
package sram_pkg;

  localparam int unsigned RdLatMin = 1;
  localparam int unsigned RdLatMax = 2;

  typedef logic [0:0] state_t;
  localparam state_t StInit = 1'b0;
  localparam state_t StIdle = 1'b1;

  // Ceiling log2 (clog2(1) = 0)
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

  // Address width never drops below one bit
  function automatic int unsigned addr_w(input int unsigned n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/sram1rw_param_if.sv
// Access bus of the single-port SRAM. O is tri-stated here under OEB so the
// memory itself only ever drives its registered read data.
interface sram1rw_param_if #(
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned WORD_LEN = 128,
  parameter int unsigned NLANE    = 16
);
  logic                CSB;
  logic                WEB;
  logic [ADDR_W-1:0]   A;
  logic [WORD_LEN-1:0] I;
  logic [NLANE-1:0]    WMB;
  logic                OEB;
  logic [WORD_LEN-1:0] dout;
  logic                OVLD;
  logic                BUSY;
  logic                ERR;
  wire  [WORD_LEN-1:0] O;

  // Output enable only gates the pins, never the read pipeline
  assign O = OEB ? {WORD_LEN{1'bz}} : dout;

  modport master (
    output CSB, WEB, A, I, WMB, OEB,
    input  O, OVLD, BUSY, ERR
  );

  modport slave (
    input  CSB, WEB, A, I, WMB,
    output dout, OVLD, BUSY, ERR
  );
endinterface

// File: rtl/sram1rw_param_lane.sv
// One GRAN-bit write lane of the SRAM array, with its own write enable.
// Contents are not reset; the controller's init sweep clears them.
module sram1rw_param_lane #(
  parameter int unsigned NUM_WORDS = 32,
  parameter int unsigned GRAN      = 8,
  parameter int unsigned ADDR_W    = 5
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [GRAN-1:0]   wdata_i,
  output logic [GRAN-1:0]   rdata_o
);

  logic [GRAN-1:0] mem_q [NUM_WORDS];

  // Storage write; the controller never enables an out-of-range address
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/sram1rw_param.sv
// Parameterised 1RW SRAM with lane write masks, a zeroing init sweep after reset,
// 1- or 2-stage registered read path and a sticky error flag.
module sram1rw_param
  import sram_pkg::*;
#(
  parameter  int unsigned NUM_WORDS = 32,
  parameter  int unsigned WORD_LEN  = 128,
  parameter  int unsigned GRAN      = 8,
  parameter  int unsigned RD_LAT    = 1,
  localparam int unsigned ADDR_W    = addr_w(NUM_WORDS),
  localparam int unsigned NLANE     = WORD_LEN / GRAN
) (
  input logic            CE,
  input logic            RSTB,
  sram1rw_param_if.slave bus
);

  if (WORD_LEN % GRAN != 0) begin : g_bad_gran
    $error("WORD_LEN must be a multiple of GRAN");
  end
  if (RD_LAT < RdLatMin || RD_LAT > RdLatMax) begin : g_bad_lat
    $error("RD_LAT must be 1 or 2");
  end
  if (NUM_WORDS < 2 || NUM_WORDS > 4096) begin : g_bad_words
    $error("NUM_WORDS must be in 2..4096");
  end

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                err_q, err_d;
  logic [WORD_LEN-1:0] s1_q, s2_q;
  logic                s1_vld_q, s2_vld_q;

  logic                busy, access, in_range, last_word, wr_fire, rd_fire;
  logic [ADDR_W-1:0]   mem_addr;
  logic [WORD_LEN-1:0] mem_wdata, mem_rdata, rd_word;
  logic [NLANE-1:0]    lane_we;

  assign busy      = (state_q == StInit);
  assign access    = ~bus.CSB;
  assign in_range  = 32'(bus.A) < NUM_WORDS;
  assign last_word = 32'(cnt_q) == NUM_WORDS - 1;
  assign wr_fire   = ~busy & access & ~bus.WEB & in_range;
  assign rd_fire   = ~busy & access & bus.WEB;

  // The sweep owns the array port while busy
  assign mem_addr  = busy ? cnt_q : bus.A;
  assign mem_wdata = busy ? '0 : bus.I;
  assign rd_word   = in_range ? mem_rdata : '0;

  for (genvar k = 0; k < NLANE; k++) begin : g_lane
    assign lane_we[k] = busy | (wr_fire & ~bus.WMB[k]);

    sram1rw_param_lane #(
      .NUM_WORDS (NUM_WORDS),
      .GRAN      (GRAN),
      .ADDR_W    (ADDR_W)
    ) u_lane (
      .clk_i   (CE),
      .we_i    (lane_we[k]),
      .addr_i  (mem_addr),
      .wdata_i (mem_wdata[k*GRAN +: GRAN]),
      .rdata_o (mem_rdata[k*GRAN +: GRAN])
    );
  end

  // Sweep sequencing: INIT walks every word once, IDLE is terminal until reset
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == StInit) begin
      cnt_d = cnt_q + 1'b1;
      if (last_word) begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    end
  end

  // Sticky error: refused access during the sweep or an out-of-range address
  always_comb begin
    err_d = err_q | (access & (busy | ~in_range));
  end

  // Controller state and read pipeline; data stages hold when no read moves through
  always_ff @(posedge CE or negedge RSTB) begin
    if (!RSTB) begin
      state_q  <= StInit;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      s1_q     <= '0;
      s1_vld_q <= 1'b0;
      s2_q     <= '0;
      s2_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      s1_vld_q <= rd_fire;
      if (rd_fire) s1_q <= rd_word;
      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) s2_q <= s1_q;
    end
  end

  assign bus.dout = (RD_LAT == RdLatMin) ? s1_q : s2_q;
  assign bus.OVLD = (RD_LAT == RdLatMin) ? s1_vld_q : s2_vld_q;
  assign bus.BUSY = busy;
  assign bus.ERR  = err_q;

endmodule
